// File: rtl/sdram_bus_adapter.sv
// sdram_bus_adapter: splits 32-bit host word transactions into two 16-bit
// sdram_controller transactions and reassembles the two read halves.
module sdram_bus_adapter #(
   parameter int AW = 24,
   parameter int DW = 16
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            host_req_valid,
   input  logic            host_req_write,
   input  logic [AW-2:0]   host_req_addr,
   input  logic [2*DW-1:0] host_req_wdata,
   input  logic [3:0]      host_req_byteenable,
   output logic            host_req_ready,
   output logic            host_rsp_valid,
   output logic [2*DW-1:0] host_rsp_rdata,
   output logic            bus_req_valid,
   output logic            bus_req_write,
   output logic [AW-1:0]   bus_req_addr,
   output logic [DW-1:0]   bus_req_wdata,
   output logic [1:0]      bus_req_byteenable,
   input  logic            bus_req_ready,
   input  logic            bus_rsp_valid,
   input  logic [DW-1:0]   bus_rsp_rdata
);
   typedef enum logic [2:0] {IDLE, REQ_LO, REQ_HI, RSP_WAIT, RSP_OUT} state_t;
   state_t state_q, state_d;
   logic [AW-2:0] addr_q, addr_d;
   logic [2*DW-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
   logic [3:0] be_q, be_d;
   logic write_q, write_d;
   logic [1:0] cnt_q, cnt_d;
   logic [DW-1:0] lo_q, lo_d;
   logic bus_valid_q, bus_valid_d, bus_write_q, bus_write_d;
   logic [AW-1:0] bus_addr_q, bus_addr_d;
   logic [DW-1:0] bus_wdata_q, bus_wdata_d;
   logic [1:0] bus_be_q, bus_be_d;
   logic accept, cap, second, hi;
   assign host_req_ready     = (state_q == IDLE) && !rst;
   assign host_rsp_valid     = state_q == RSP_OUT;
   assign host_rsp_rdata     = rdata_q;
   assign bus_req_valid      = bus_valid_q;
   assign bus_req_write      = bus_write_q;
   assign bus_req_addr       = bus_addr_q;
   assign bus_req_wdata      = bus_wdata_q;
   assign bus_req_byteenable = bus_be_q;
   always_comb begin
      accept  = host_req_valid && (state_q == IDLE);
      cap     = bus_rsp_valid && (state_q != IDLE) && (cnt_q != 2'd2);
      second  = cap && (cnt_q == 2'd1);
      addr_d  = accept ? host_req_addr : addr_q;
      wdata_d = accept ? host_req_wdata : wdata_q;
      be_d    = accept ? host_req_byteenable : be_q;
      write_d = accept ? host_req_write : write_q;
      cnt_d   = accept ? 2'd0 : cap ? cnt_q + 2'd1 : cnt_q;
      lo_d    = (cap && cnt_q == 2'd0) ? bus_rsp_rdata : lo_q;
      rdata_d = second ? {bus_rsp_rdata, lo_q} : rdata_q;
      state_d = state_q;
      case (state_q)
         IDLE:     if (accept) state_d = (!host_req_write || host_req_byteenable[1:0] != 2'b00) ? REQ_LO :
                                         (host_req_byteenable[3:2] != 2'b00) ? REQ_HI : IDLE;
         REQ_LO:   if (bus_req_ready) state_d = (write_q && be_q[3:2] == 2'b00) ? IDLE : REQ_HI;
         REQ_HI:   if (bus_req_ready) state_d = write_q ? IDLE : (second || cnt_q == 2'd2) ? RSP_OUT : RSP_WAIT;
         RSP_WAIT: if (second) state_d = RSP_OUT;
         default:  state_d = IDLE;
      endcase
      // bus outputs are registered from the next state, so they hold while stalled
      hi          = state_d == REQ_HI;
      bus_valid_d = (state_d == REQ_LO) || hi;
      bus_write_d = write_d;
      bus_addr_d  = {addr_d, hi};
      bus_wdata_d = hi ? wdata_d[2*DW-1:DW] : wdata_d[DW-1:0];
      bus_be_d    = hi ? be_d[3:2] : be_d[1:0];
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         addr_q      <= '0;
         wdata_q     <= '0;
         be_q        <= '0;
         write_q     <= 1'b0;
         cnt_q       <= '0;
         lo_q        <= '0;
         rdata_q     <= '0;
         bus_valid_q <= 1'b0;
         bus_write_q <= 1'b0;
         bus_addr_q  <= '0;
         bus_wdata_q <= '0;
         bus_be_q    <= '0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         be_q        <= be_d;
         write_q     <= write_d;
         cnt_q       <= cnt_d;
         lo_q        <= lo_d;
         rdata_q     <= rdata_d;
         bus_valid_q <= bus_valid_d;
         bus_write_q <= bus_write_d;
         bus_addr_q  <= bus_addr_d;
         bus_wdata_q <= bus_wdata_d;
         bus_be_q    <= bus_be_d;
      end
   end
endmodule

// File: tb/tb_sdram_bus_adapter.sv
// tb_sdram_bus_adapter: vector table of host transactions against a small
// controller model; bus requests and host responses are scoreboarded.
module tb_sdram_bus_adapter;
   logic clk, rst;
   logic host_req_valid, host_req_write, host_req_ready, host_rsp_valid;
   logic [22:0] host_req_addr;
   logic [31:0] host_req_wdata, host_rsp_rdata;
   logic [3:0] host_req_byteenable;
   logic bus_req_valid, bus_req_write, bus_req_ready, bus_rsp_valid;
   logic [23:0] bus_req_addr;
   logic [15:0] bus_req_wdata, bus_rsp_rdata;
   logic [1:0] bus_req_byteenable;

   sdram_bus_adapter #(.AW(24), .DW(16)) dut (
      .clk(clk), .rst(rst),
      .host_req_valid(host_req_valid), .host_req_write(host_req_write),
      .host_req_addr(host_req_addr), .host_req_wdata(host_req_wdata),
      .host_req_byteenable(host_req_byteenable), .host_req_ready(host_req_ready),
      .host_rsp_valid(host_rsp_valid), .host_rsp_rdata(host_rsp_rdata),
      .bus_req_valid(bus_req_valid), .bus_req_write(bus_req_write),
      .bus_req_addr(bus_req_addr), .bus_req_wdata(bus_req_wdata),
      .bus_req_byteenable(bus_req_byteenable), .bus_req_ready(bus_req_ready),
      .bus_rsp_valid(bus_rsp_valid), .bus_rsp_rdata(bus_rsp_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic w; logic [22:0] a; logic [31:0] d; logic [3:0] be;
      int slo; int shi; int dly; logic [15:0] rlo; logic [15:0] rhi;
      logic [31:0] rd; int busy;
   } vec_t;
   typedef struct {
      logic w; logic [23:0] a; logic [15:0] d; logic [1:0] be;
      int stall; int dly; logic [15:0] rsp;
   } bus_t;
   typedef struct {int due; logic [15:0] d; bit second;} rsp_t;

   bus_t exp_bus[$];
   logic [31:0] exp_rsp[$];
   rsp_t pending[$];
   int checks = 0, errors = 0, cyc = 0, stall_left = 0;
   bit in_req = 0, sec_prev = 0, spur = 0;
   vec_t vecs[11];

   task automatic chk(input bit ok, input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   // controller model: stalls per request, answers reads after a delay
   initial begin
      logic [42:0] cur, ex;
      bus_t b;
      rsp_t p;
      bus_req_ready = 1'b1;
      bus_rsp_valid = 1'b0;
      bus_rsp_rdata = '0;
      forever begin
         @(negedge clk);
         cyc++;
         if (rst) begin
            pending.delete();
            in_req = 0;
            sec_prev = 0;
            bus_rsp_valid = 1'b0;
            bus_req_ready = 1'b1;
         end else begin
            if (host_rsp_valid || sec_prev)
               chk(host_rsp_valid == sec_prev, "rsp_timing", 64'(host_rsp_valid), 64'(sec_prev));
            if (host_rsp_valid) begin
               if (exp_rsp.size() == 0) chk(0, "rsp_unexpected", 64'(host_rsp_rdata), 0);
               else begin
                  ex[31:0] = exp_rsp.pop_front();
                  chk(host_rsp_rdata == ex[31:0], "rsp_data", 64'(host_rsp_rdata), 64'(ex[31:0]));
               end
            end
            sec_prev = 0;
            bus_req_ready = 1'b1;
            if (bus_req_valid) begin
               cur = {bus_req_write, bus_req_addr, bus_req_wdata, bus_req_byteenable};
               if (exp_bus.size() == 0) chk(0, "bus_unexpected", 64'(cur), 0);
               else begin
                  if (!in_req) begin
                     stall_left = exp_bus[0].stall;
                     in_req = 1;
                  end else chk(cur == ex, "bus_stable", 64'(cur), 64'(ex));
                  ex = cur;
                  if (stall_left > 0) begin
                     bus_req_ready = 1'b0;
                     stall_left--;
                  end else begin
                     in_req = 0;
                     b = exp_bus.pop_front();
                     ex = {b.w, b.a, b.d, b.be};
                     chk(cur == ex, "bus_req", 64'(cur), 64'(ex));
                     if (!b.w) pending.push_back('{cyc + b.dly, b.rsp, b.a[0]});
                  end
               end
            end
            bus_rsp_valid = 1'b0;
            if (spur) begin
               bus_rsp_valid = 1'b1;
               bus_rsp_rdata = 16'hFFFF;
               spur = 0;
            end else if (pending.size() > 0 && pending[0].due <= cyc) begin
               p = pending.pop_front();
               bus_rsp_valid = 1'b1;
               bus_rsp_rdata = p.d;
               sec_prev = p.second;
            end
         end
      end
   end

   task automatic launch(input vec_t v);
      int n;
      if (v.w) begin
         if (v.be[1:0] != 0) exp_bus.push_back('{1'b1, {v.a, 1'b0}, v.d[15:0], v.be[1:0], v.slo, 0, 16'h0});
         if (v.be[3:2] != 0) exp_bus.push_back('{1'b1, {v.a, 1'b1}, v.d[31:16], v.be[3:2], v.shi, 0, 16'h0});
      end else begin
         exp_bus.push_back('{1'b0, {v.a, 1'b0}, v.d[15:0], v.be[1:0], v.slo, v.dly, v.rlo});
         exp_bus.push_back('{1'b0, {v.a, 1'b1}, v.d[31:16], v.be[3:2], v.shi, v.dly, v.rhi});
         exp_rsp.push_back(v.rd);
      end
      @(negedge clk);
      n = 0;
      while (!host_req_ready && n < 100) begin
         n++;
         @(negedge clk);
      end
      if (n >= 100) chk(0, "ready_timeout", 0, 1);
      host_req_valid = 1'b1;
      host_req_write = v.w;
      host_req_addr = v.a;
      host_req_wdata = v.d;
      host_req_byteenable = v.be;
      @(negedge clk);
      host_req_valid = 1'b0;
   endtask

   task automatic apply(input vec_t v);
      int busy, n;
      launch(v);
      busy = 0;
      while (!host_req_ready && busy < 100) begin
         busy++;
         @(negedge clk);
      end
      chk(busy == v.busy, "busy_cycles", 64'(busy), 64'(v.busy));
      n = 0;
      while ((exp_bus.size() != 0 || exp_rsp.size() != 0 || pending.size() != 0) && n < 50) begin
         n++;
         @(negedge clk);
      end
      chk(n < 50, "drain", 64'(exp_bus.size() + exp_rsp.size()), 0);
   endtask

   initial begin
      vecs[0]  = '{1'b1, 23'h012345, 32'hDEADBEEF, 4'hF, 0, 0, 0, 16'h0, 16'h0, 32'h0, 2};
      vecs[1]  = '{1'b1, 23'h000ABC, 32'hAABBCCDD, 4'hC, 0, 0, 0, 16'h0, 16'h0, 32'h0, 1};
      vecs[2]  = '{1'b1, 23'h000123, 32'h11223344, 4'h0, 0, 0, 0, 16'h0, 16'h0, 32'h0, 0};
      vecs[3]  = '{1'b1, 23'h7FFFFF, 32'hCAFEF00D, 4'h3, 0, 0, 0, 16'h0, 16'h0, 32'h0, 1};
      vecs[4]  = '{1'b0, 23'h000010, 32'h0, 4'hF, 0, 0, 1, 16'h5678, 16'h1234, 32'h12345678, 4};
      vecs[5]  = '{1'b0, 23'h000020, 32'h0, 4'hF, 5, 0, 1, 16'hBEEF, 16'hDEAD, 32'hDEADBEEF, 9};
      vecs[6]  = '{1'b0, 23'h000030, 32'h0, 4'hF, 0, 3, 1, 16'h0F0F, 16'hF0F0, 32'hF0F00F0F, 7};
      vecs[7]  = '{1'b0, 23'h7FFFFF, 32'h0, 4'hF, 0, 0, 0, 16'h0001, 16'h8000, 32'h80000001, 3};
      vecs[8]  = '{1'b0, 23'h000001, 32'h0, 4'hF, 0, 0, 3, 16'hAAAA, 16'h5555, 32'h5555AAAA, 6};
      vecs[9]  = '{1'b1, 23'h000040, 32'h01020304, 4'h5, 0, 0, 0, 16'h0, 16'h0, 32'h0, 2};
      vecs[10] = '{1'b1, 23'h000050, 32'h89ABCDEF, 4'hF, 2, 0, 0, 16'h0, 16'h0, 32'h0, 4};
      rst = 1'b1;
      host_req_valid = 1'b0;
      host_req_write = 1'b0;
      host_req_addr = '0;
      host_req_wdata = '0;
      host_req_byteenable = '0;
      repeat (2) @(negedge clk);
      chk(host_req_ready == 1'b0, "rst_ready", 64'(host_req_ready), 0);
      chk(bus_req_valid == 1'b0, "rst_bus_valid", 64'(bus_req_valid), 0);
      chk(host_rsp_valid == 1'b0, "rst_rsp_valid", 64'(host_rsp_valid), 0);
      chk({host_rsp_rdata, bus_req_addr} == 56'h0, "rst_regs", {host_rsp_rdata, bus_req_addr}, 0);
      rst = 1'b0;
      @(negedge clk);
      chk(host_req_ready == 1'b1, "ready_after_rst", 64'(host_req_ready), 1);
      for (int i = 0; i < 11; i++) apply(vecs[i]);
      chk(host_rsp_rdata == 32'h5555AAAA, "rdata_hold", 64'(host_rsp_rdata), 64'h5555AAAA);
      // spurious response in IDLE must not disturb the next read
      spur = 1;
      repeat (3) @(negedge clk);
      apply('{1'b0, 23'h000060, 32'h0, 4'hF, 0, 0, 1, 16'h0001, 16'h0002, 32'h00020001, 4});
      // reset while parked in RSP_WAIT
      launch('{1'b0, 23'h000070, 32'h0, 4'hF, 0, 0, 6, 16'h1111, 16'h2222, 32'h22221111, 0});
      repeat (3) @(negedge clk);
      #1 rst = 1'b1;
      #1;
      chk(bus_req_valid == 1'b0, "rstw_bus_valid", 64'(bus_req_valid), 0);
      chk(host_rsp_valid == 1'b0, "rstw_rsp_valid", 64'(host_rsp_valid), 0);
      chk(host_req_ready == 1'b0, "rstw_ready", 64'(host_req_ready), 0);
      exp_bus.delete();
      exp_rsp.delete();
      @(negedge clk);
      #1 rst = 1'b0;
      #1 chk(host_req_ready == 1'b1, "rstw_ready_rel", 64'(host_req_ready), 1);
      // reset while a stalled LO request is on the bus
      launch('{1'b0, 23'h000080, 32'h0, 4'hF, 10, 0, 1, 16'h3333, 16'h4444, 32'h44443333, 0});
      @(negedge clk);
      #1 chk(bus_req_valid == 1'b1, "stall_bus_valid", 64'(bus_req_valid), 1);
      rst = 1'b1;
      #1;
      chk(bus_req_valid == 1'b0, "rsts_bus_valid", 64'(bus_req_valid), 0);
      chk(host_req_ready == 1'b0, "rsts_ready", 64'(host_req_ready), 0);
      exp_bus.delete();
      exp_rsp.delete();
      @(negedge clk);
      #1 rst = 1'b0;
      #1 chk(host_req_ready == 1'b1 && bus_req_valid == 1'b0, "rsts_release", {bus_req_valid, host_req_ready}, 64'h1);
      apply('{1'b0, 23'h000090, 32'h0, 4'hF, 0, 0, 1, 16'hC0DE, 16'hFACE, 32'hFACEC0DE, 4});
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
